// File: rtl/seed_lfsr_xy.sv
// Seed consumer: captures a 16-bit seed into a Fibonacci LFSR and, on request,
// rejection-samples a bounded (x, y) coordinate pair with a forced fallback.
module seed_lfsr_xy #(
    parameter int COORD_W   = 3,
    parameter int X_LIMIT   = 6,
    parameter int Y_LIMIT   = 6,
    parameter int MAX_TRIES = 16
) (
    input  logic               CLK500Hz,
    input  logic               rstn,
    input  logic [15:0]        seed,
    input  logic               seed_load,
    input  logic               req,
    output logic               busy,
    output logic               seeded,
    output logic               valid,
    output logic               forced,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic [15:0]        lfsr_state
);

    typedef enum logic [1:0] {
        UNSEEDED,
        READY,
        GEN
    } state_e;

    // One extra bit so a limit of 2^COORD_W accepts every candidate.
    localparam logic [COORD_W:0]   XLIM    = (COORD_W+1)'(X_LIMIT);
    localparam logic [COORD_W:0]   YLIM    = (COORD_W+1)'(Y_LIMIT);
    localparam logic [COORD_W-1:0] XFORCE  = COORD_W'(X_LIMIT - 1);
    localparam logic [COORD_W-1:0] YFORCE  = COORD_W'(Y_LIMIT - 1);
    localparam logic [7:0]         LASTTRY = 8'(MAX_TRIES - 1);

    state_e               state_q, state_d;
    logic [15:0]          lfsr_q, lfsr_d;
    logic [7:0]           tries_q, tries_d;
    logic                 seeded_q, seeded_d;
    logic                 valid_q, valid_d;
    logic                 forced_q, forced_d;
    logic [COORD_W-1:0]   x_q, x_d;
    logic [COORD_W-1:0]   y_q, y_d;

    logic [15:0]          lfsrNext;
    logic [COORD_W-1:0]   cx, cy;
    logic                 accept;

    assign lfsrNext = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    assign cx       = lfsrNext[COORD_W-1:0];
    assign cy       = lfsrNext[2*COORD_W-1:COORD_W];
    assign accept   = ({1'b0, cx} < XLIM) && ({1'b0, cy} < YLIM);

    always_ff @(posedge CLK500Hz or negedge rstn) begin
        if (!rstn) begin
            state_q  <= UNSEEDED;
            lfsr_q   <= 16'h0000;
            tries_q  <= 8'd0;
            seeded_q <= 1'b0;
            valid_q  <= 1'b0;
            forced_q <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
        end else begin
            state_q  <= state_d;
            lfsr_q   <= lfsr_d;
            tries_q  <= tries_d;
            seeded_q <= seeded_d;
            valid_q  <= valid_d;
            forced_q <= forced_d;
            x_q      <= x_d;
            y_q      <= y_d;
        end
    end

    // A seed load overrides everything, including a request in flight.
    always_comb begin
        state_d  = state_q;
        lfsr_d   = lfsr_q;
        tries_d  = tries_q;
        seeded_d = seeded_q;
        valid_d  = valid_q;
        forced_d = forced_q;
        x_d      = x_q;
        y_d      = y_q;
        if (seed_load) begin
            lfsr_d   = (seed == 16'h0000) ? 16'hACE1 : seed;
            seeded_d = 1'b1;
            valid_d  = 1'b0;
            forced_d = 1'b0;
            tries_d  = 8'd0;
            state_d  = READY;
        end else begin
            case (state_q)
                UNSEEDED: state_d = UNSEEDED;
                READY: begin
                    if (req) begin
                        state_d = GEN;
                        tries_d = 8'd0;
                        valid_d = 1'b0;
                    end
                end
                GEN: begin
                    lfsr_d  = lfsrNext;
                    tries_d = tries_q + 8'd1;
                    if (accept) begin
                        x_d      = cx;
                        y_d      = cy;
                        valid_d  = 1'b1;
                        forced_d = 1'b0;
                        state_d  = READY;
                    end else if (tries_q == LASTTRY) begin
                        x_d      = XFORCE;
                        y_d      = YFORCE;
                        valid_d  = 1'b1;
                        forced_d = 1'b1;
                        state_d  = READY;
                    end
                end
                default: state_d = UNSEEDED;
            endcase
        end
    end

    assign busy       = (state_q == GEN);
    assign seeded     = seeded_q;
    assign valid      = valid_q;
    assign forced     = forced_q;
    assign x          = x_q;
    assign y          = y_q;
    assign lfsr_state = lfsr_q;

endmodule

// File: tb/tb_seed_lfsr_xy.sv
// Self-checking bench: two instances (default limits and a tight 1x1/4-try
// variant) driven with directed and random seeds against a transaction model.
module tb_seed_lfsr_xy;

    logic        clk = 1'b0;
    logic        rstn;
    logic [15:0] seedA, seedB;
    logic        loadA, loadB, reqA, reqB;
    logic        busyA, seededA, validA, forcedA;
    logic        busyB, seededB, validB, forcedB;
    logic [2:0]  xA, yA, xB, yB;
    logic [15:0] lfsrA, lfsrB;

    int          testCount = 0;
    int          failCount = 0;
    logic [15:0] mLfsrA, mLfsrB;

    always #5 clk = ~clk;

    seed_lfsr_xy dutA (
        .CLK500Hz(clk), .rstn(rstn), .seed(seedA), .seed_load(loadA), .req(reqA),
        .busy(busyA), .seeded(seededA), .valid(validA), .forced(forcedA),
        .x(xA), .y(yA), .lfsr_state(lfsrA)
    );

    seed_lfsr_xy #(.COORD_W(3), .X_LIMIT(1), .Y_LIMIT(1), .MAX_TRIES(4)) dutB (
        .CLK500Hz(clk), .rstn(rstn), .seed(seedB), .seed_load(loadB), .req(reqB),
        .busy(busyB), .seeded(seededB), .valid(validB), .forced(forcedB),
        .x(xB), .y(yB), .lfsr_state(lfsrB)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testCount++;
        assert (obs === exp)
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Feedback taps 16,14,13,11 as plain integer arithmetic.
    function automatic logic [15:0] lfsrStep(input logic [15:0] s);
        int v;
        int fb;
        v  = int'(s);
        fb = ((v >> 15) ^ (v >> 13) ^ (v >> 12) ^ (v >> 10)) & 1;
        return 16'((v * 2 + fb) % 65536);
    endfunction

    // Whole-request model: steps until a candidate fits or tries run out.
    task automatic modelRequest(input int xl, input int yl, input int mt, inout logic [15:0] s,
                                output int steps, output int mx, output int my, output bit mf);
        bit done;
        int cxv, cyv;
        done  = 0;
        steps = 0;
        mx    = xl - 1;
        my    = yl - 1;
        mf    = 1;
        for (int i = 1; i <= mt; i++) begin
            if (!done) begin
                s     = lfsrStep(s);
                steps = i;
                cxv   = int'(s) % 8;
                cyv   = (int'(s) / 8) % 8;
                if (cxv < xl && cyv < yl) begin
                    mx   = cxv;
                    my   = cyv;
                    mf   = 0;
                    done = 1;
                end
            end
        end
    endtask

    task automatic loadSeed(input bit useB, input logic [15:0] s);
        logic [15:0] expL;
        expL = (s == 16'h0000) ? 16'hACE1 : s;
        if (useB) begin
            seedB = s;
            loadB = 1'b1;
            mLfsrB = expL;
        end else begin
            seedA = s;
            loadA = 1'b1;
            mLfsrA = expL;
        end
        @(negedge clk);
        loadA = 1'b0;
        loadB = 1'b0;
        checkOutput("load lfsr",   32'(useB ? lfsrB : lfsrA), 32'(expL));
        checkOutput("load seeded", 32'(useB ? seededB : seededA), 32'd1);
        checkOutput("load valid",  32'(useB ? validB : validA), 32'd0);
        checkOutput("load busy",   32'(useB ? busyB : busyA), 32'd0);
    endtask

    task automatic applyStimulus(input bit useB);
        logic [15:0] s;
        int steps, mx, my, cnt;
        bit mf;
        s = useB ? mLfsrB : mLfsrA;
        modelRequest(useB ? 1 : 6, useB ? 1 : 6, useB ? 4 : 16, s, steps, mx, my, mf);
        if (useB) reqB = 1'b1; else reqA = 1'b1;
        @(negedge clk);
        reqA = 1'b0;
        reqB = 1'b0;
        checkOutput("req busy",  32'(useB ? busyB : busyA), 32'd1);
        checkOutput("req valid", 32'(useB ? validB : validA), 32'd0);
        cnt = 0;
        while ((useB ? busyB : busyA) === 1'b1 && cnt < 40) begin
            cnt++;
            @(negedge clk);
        end
        checkOutput("gen cycles", 32'(cnt), 32'(steps));
        checkOutput("res valid",  32'(useB ? validB : validA), 32'd1);
        checkOutput("res forced", 32'(useB ? forcedB : forcedA), 32'(mf));
        checkOutput("res x",      32'(useB ? xB : xA), 32'(mx));
        checkOutput("res y",      32'(useB ? yB : yA), 32'(my));
        checkOutput("res lfsr",   32'(useB ? lfsrB : lfsrA), 32'(s));
        if (useB) mLfsrB = s; else mLfsrA = s;
    endtask

    initial begin
        rstn  = 1'b0;
        seedA = '0; seedB = '0;
        loadA = 1'b0; loadB = 1'b0;
        reqA  = 1'b0; reqB  = 1'b0;
        mLfsrA = '0; mLfsrB = '0;
        #2;
        checkOutput("reset A", 32'({busyA, seededA, validA, forcedA, xA, yA, lfsrA}), 32'd0);
        checkOutput("reset B", 32'({busyB, seededB, validB, forcedB, xB, yB, lfsrB}), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        // Request before any seed is ignored.
        reqA = 1'b1;
        @(negedge clk);
        reqA = 1'b0;
        checkOutput("unseeded busy",   32'(busyA), 32'd0);
        checkOutput("unseeded valid",  32'(validA), 32'd0);
        checkOutput("unseeded seeded", 32'(seededA), 32'd0);

        loadSeed(0, 16'd8808);
        checkOutput("seed 8808 lfsr", 32'(lfsrA), 32'h2268);
        applyStimulus(0);
        checkOutput("t2 x1",    32'(xA), 32'd1);
        checkOutput("t2 y1",    32'(yA), 32'd2);
        checkOutput("t2 lfsr1", 32'(lfsrA), 32'h44D1);
        applyStimulus(0);
        checkOutput("t2 x2",    32'(xA), 32'd3);
        checkOutput("t2 y2",    32'(yA), 32'd4);
        checkOutput("t2 lfsr2", 32'(lfsrA), 32'h89A3);

        loadSeed(0, 16'h0000);
        applyStimulus(0);
        checkOutput("t3 x",    32'(xA), 32'd3);
        checkOutput("t3 y",    32'(yA), 32'd0);
        checkOutput("t3 lfsr", 32'(lfsrA), 32'h59C3);
        repeat (3) @(negedge clk);
        checkOutput("hold valid", 32'(validA), 32'd1);
        checkOutput("hold xy",    32'({xA, yA}), 32'({3'd3, 3'd0}));

        loadSeed(1, 16'd8808);
        applyStimulus(1);
        checkOutput("t4 forced", 32'(forcedB), 32'd1);
        checkOutput("t4 xy",     32'({xB, yB}), 32'd0);
        checkOutput("t4 lfsr",   32'(lfsrB), 32'h268F);

        // Seed load on the second GEN cycle aborts the request.
        loadSeed(1, 16'd8808);
        reqB = 1'b1;
        @(negedge clk);
        reqB = 1'b0;
        @(negedge clk);
        seedB = 16'd8808;
        loadB = 1'b1;
        @(negedge clk);
        loadB = 1'b0;
        mLfsrB = 16'h2268;
        checkOutput("abort busy",  32'(busyB), 32'd0);
        checkOutput("abort valid", 32'(validB), 32'd0);
        checkOutput("abort lfsr",  32'(lfsrB), 32'h2268);
        @(negedge clk);
        checkOutput("abort no result", 32'({busyB, validB}), 32'd0);
        seedB = 16'h1234;
        loadB = 1'b1;
        reqB  = 1'b1;
        @(negedge clk);
        loadB = 1'b0;
        reqB  = 1'b0;
        mLfsrB = 16'h1234;
        checkOutput("load wins busy", 32'(busyB), 32'd0);
        checkOutput("load wins lfsr", 32'(lfsrB), 32'h1234);
        @(negedge clk);
        checkOutput("load wins stays", 32'({busyB, lfsrB}), 32'h1234);

        for (int i = 0; i < 8; i++) begin
            loadSeed(0, 16'($urandom));
            for (int j = 0; j < int'($urandom_range(1, 4)); j++) applyStimulus(0);
            loadSeed(1, 16'($urandom));
            applyStimulus(1);
        end

        // Asynchronous reset in the middle of GEN.
        loadSeed(1, 16'd8808);
        reqB = 1'b1;
        @(negedge clk);
        reqB = 1'b0;
        @(posedge clk);
        #2 rstn = 1'b0;
        #1;
        checkOutput("midgen reset B", 32'({busyB, seededB, validB, forcedB, xB, yB, lfsrB}), 32'd0);
        checkOutput("midgen reset A", 32'({busyA, seededA, validA, forcedA, xA, yA, lfsrA}), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        reqB = 1'b1;
        @(negedge clk);
        reqB = 1'b0;
        checkOutput("post reset req", 32'({busyB, validB, seededB}), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
